sync_fifo_flex: RTL and testbench

Parametrised single-clock FIFO, successor to the basic synchronous FIFO. Adds configurable almost-full/almost-empty thresholds, a compile-time selectable first-word-fall-through (FWFT) read mode, a read-valid strobe for the registered mode, and full-with-simultaneous-read acceptance. It sits between any producer/consumer pair in one clock domain: stream buffers, UART/SPI byte queues, pipeline decoupling.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/fifo_ram.sv | 21 ++
 rtl/sync_fifo_flex.sv | 97 +++++++++
 tb/tb_sync_fifo_flex.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared constants and sizing helpers for sync_fifo_flex
// Contents: FIFO_MODE_REG / FIFO_MODE_FWFT read-mode selectors,
// addr_width / ptr_width sizing helpers, is_pow2 depth check.
package sync_fifo_pkg;
    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra wrap bit distinguishes full from empty
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int depth);
        return depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DATA_WIDTH x DEPTH simple dual-port RAM, sync write, async read, no reset
// Ports: clk, we/waddr/wdata write port, raddr/rdata combinational read port.
module fifo_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock FIFO with thresholds, selectable FWFT and optional error flags
// Ports: clk, rst (sync, active-high); write side wr_data/wr_en/full/almost_full;
// read side rd_en/rd_data/rd_valid/empty/almost_empty; count (0..DEPTH).
// Macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module sync_fifo_flex
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = FIFO_MODE_REG
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        wr_en,
    output logic                        full,
    output logic                        almost_full,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic                        rd_valid,
    output logic                        empty,
    output logic                        almost_empty,
    output logic [ptr_width(DEPTH)-1:0] count
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic                        overflow,
    output logic                        underflow
`endif
);
    localparam int PW = ptr_width(DEPTH);
    localparam int AW = addr_width(DEPTH);

    if (!is_pow2(DEPTH) || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1 ||
        (FWFT != FIFO_MODE_REG && FWFT != FIFO_MODE_FWFT)) begin : g_bad_cfg
        $error("sync_fifo_flex: invalid DEPTH, threshold or FWFT parameter");
    end

    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] head;
    logic                  rd_acc, wr_acc;

    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = count >= PW'(AFULL_THRESH);
    assign almost_empty = count <= PW'(AEMPTY_THRESH);
    assign rd_acc       = rd_en && !empty;
    // A read in the same cycle frees the slot the write lands in
    assign wr_acc       = wr_en && (!full || rd_acc);

    always_ff @(posedge clk)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
        end

    // Async read sees the old head even when a full-FIFO write targets the same slot
    fifo_ram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        assign rd_data  = head;
        assign rd_valid = !empty;
    end else begin : g_reg
        always_ff @(posedge clk)
            if (rst) begin
                rd_data  <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= rd_acc;
                if (rd_acc) rd_data <= head;
            end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk)
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && !wr_acc) overflow <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
`endif
endmodule

// File: tb/tb_sync_fifo_flex.sv
// tb_sync_fifo_flex: directed self-checking bench for registered and FWFT builds of sync_fifo_flex
module tb_sync_fifo_flex;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en, rd_en;
    logic       full_a, afull_a, empty_a, aempty_a, rv_a;
    logic       full_b, afull_b, empty_b, aempty_b, rv_b;
    logic [7:0] rd_a, rd_b;
    logic [4:0] cnt_a, cnt_b;
`ifdef FIFO_ERR_FLAGS_EN
    logic       ovf_a, unf_a, ovf_b, unf_b;
`endif
    int total = 0;
    int bad = 0;
    int q[$];

    always #5 clk = ~clk;

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) dut_a (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full_a),
        .almost_full(afull_a), .rd_en(rd_en), .rd_data(rd_a), .rd_valid(rv_a),
        .empty(empty_a), .almost_empty(aempty_a), .count(cnt_a)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(ovf_a), .underflow(unf_a)
`endif
    );

    sync_fifo_flex #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) dut_b (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full_b),
        .almost_full(afull_b), .rd_en(rd_en), .rd_data(rd_b), .rd_valid(rv_b),
        .empty(empty_b), .almost_empty(aempty_b), .count(cnt_b)
`ifdef FIFO_ERR_FLAGS_EN
        , .overflow(ovf_b), .underflow(unf_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] pat;
        logic       racc, wacc;
        int         popped;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
        step(); step();
        rst = 1'b0;
        step();
        check("rst_empty", 32'(empty_a), 32'd1);
        check("rst_aempty", 32'(aempty_a), 32'd1);
        check("rst_count", 32'(cnt_a), 32'd0);
        check("rst_full", 32'(full_a), 32'd0);
        check("rst_afull", 32'(afull_a), 32'd0);
        check("rst_rvalid", 32'(rv_a), 32'd0);
        check("rst_rdata", 32'(rd_a), 32'd0);
        check("rst_rvalid_fwft", 32'(rv_b), 32'd0);

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            check("fill_count", 32'(cnt_a), 32'(i + 1));
            check("fill_afull", 32'(afull_a), 32'(i + 1 >= 14));
            check("fill_full", 32'(full_a), 32'(i == 15));
            check("fill_empty_fwft", 32'(empty_b), 32'd0);
        end
        wr_en = 1'b0;

        for (int i = 0; i < 16; i++) begin
            check("drain_fwft_head", 32'(rd_b), 32'(i));
            rd_en = 1'b1;
            step();
            check("drain_data", 32'(rd_a), 32'(i));
            check("drain_valid", 32'(rv_a), 32'd1);
            check("drain_count", 32'(cnt_a), 32'(15 - i));
        end
        rd_en = 1'b0;
        step();
        check("idle_valid", 32'(rv_a), 32'd0);
        check("idle_hold", 32'(rd_a), 32'h0f);
        check("idle_empty", 32'(empty_a), 32'd1);
        check("idle_aempty", 32'(aempty_a), 32'd1);

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        wr_data = 8'hee;
        step();
        check("ovf_count", 32'(cnt_a), 32'd16);
        check("ovf_full", 32'(full_a), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check("ovf_flag", 32'(ovf_a), 32'd1);
        check("ovf_no_unf", 32'(unf_a), 32'd0);
`endif
        rd_en = 1'b1; wr_data = 8'hab;
        step();
        check("fullrw_data", 32'(rd_a), 32'h00);
        check("fullrw_valid", 32'(rv_a), 32'd1);
        check("fullrw_count", 32'(cnt_a), 32'd16);
        check("fullrw_full", 32'(full_a), 32'd1);
        check("fullrw_fwft_head", 32'(rd_b), 32'h01);
        wr_en = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("fullrw_drain", 32'(rd_a), (i == 16) ? 32'hab : 32'(i));
        end
        rd_en = 1'b0;
        step();
        check("fullrw_empty", 32'(empty_a), 32'd1);

        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5a;
        step();
        check("emptyrw_valid", 32'(rv_a), 32'd0);
        check("emptyrw_count", 32'(cnt_a), 32'd1);
        check("emptyrw_hold", 32'(rd_a), 32'hab);
`ifdef FIFO_ERR_FLAGS_EN
        check("unf_flag", 32'(unf_a), 32'd1);
`endif
        wr_en = 1'b0; rd_en = 1'b0;
        step();
        check("emptyrw_fwft_data", 32'(rd_b), 32'h5a);
        check("emptyrw_fwft_valid", 32'(rv_b), 32'd1);
        rd_en = 1'b1;
        step();
        check("emptyrw_pop", 32'(rd_a), 32'h5a);
        check("emptyrw_fwft_empty", 32'(rv_b), 32'd0);
        rd_en = 1'b0;

        pat = 8'h20;
        q.delete();
        for (int c = 0; c < 64; c++) begin
            wr_en = (c < 40) && (c % 3 != 2);
            rd_en = (c % 2 == 1) || (c >= 40);
            wr_data = pat;
            racc = rd_en && q.size() > 0;
            wacc = wr_en && (q.size() < 16 || racc);
            if (q.size() > 0) check("wrap_fwft_head", 32'(rd_b), 32'(q[0]));
            step();
            popped = 0;
            if (racc) popped = q.pop_front();
            if (wacc) begin
                q.push_back(int'(pat));
                pat = pat + 8'd1;
            end
            check("wrap_valid", 32'(rv_a), 32'(racc));
            if (racc) check("wrap_data", 32'(rd_a), 32'(popped));
            check("wrap_count", 32'(cnt_a), 32'(q.size()));
            if (cnt_a > 5'd16) check("wrap_count_max", 32'(cnt_a), 32'd16);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        check("wrap_end_empty", 32'(empty_a), 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        check("sticky_ovf", 32'(ovf_a), 32'd1);
        check("sticky_unf", 32'(unf_a), 32'd1);
`endif

        wr_en = 1'b1; wr_data = 8'h11;
        step(); step(); step();
        check("pre_rst_count", 32'(cnt_a), 32'd3);
        rst = 1'b1;
        step();
        check("midrst_count", 32'(cnt_a), 32'd0);
        check("midrst_empty", 32'(empty_a), 32'd1);
        check("midrst_rvalid", 32'(rv_a), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_unf", 32'(unf_a), 32'd0);
`endif
        rst = 1'b0; wr_en = 1'b0;
        step();
        check("post_rst_count", 32'(cnt_a), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
